simple_expect_src: RTL and testbench

Streaming source for the expected-value channel consumed by the error stage. Holds a frame of `float_24_8` targets in an internal RAM loaded through a write port. On `start` it replays the frame as a valid/ready/first stream (`expected`, `expected_fst`, `expected_vld` / `expected_rdy`). It sits upstream of the error block, opposite the stage output stream.

---
 rtl/simple_expect_src_pkg.sv | 14 +
 rtl/simple_expect_src_if.sv | 12 +
 rtl/simple_expect_src_mem.sv | 24 ++
 rtl/simple_expect_src.sv | 118 +++++++++++
 tb/tb_simple_expect_src.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/simple_expect_src_pkg.sv
// Shared types for the expected-value stream source: data format, FSM states, FIFO sizing.
package simple_expect_src_pkg;

  typedef logic [31:0] float_24_8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } simple_expect_src_state_t;

  localparam int SIMPLE_EXPECT_SRC_FIFO_DEPTH = 2;

endpackage

// File: rtl/simple_expect_src_if.sv
// Valid/ready/first stream carrying expected values toward the error stage.
interface simple_expect_src_if;
  import simple_expect_src_pkg::*;

  float_24_8 expected;
  logic      expected_fst;
  logic      expected_vld;
  logic      expected_rdy;

  modport master (output expected, expected_fst, expected_vld, input expected_rdy);
  modport slave  (input expected, expected_fst, expected_vld, output expected_rdy);
endinterface

// File: rtl/simple_expect_src_mem.sv
// DEPTH x 32 RAM, one write and one read port, 1-cycle read latency, read-before-write.
module simple_expect_src_mem
  import simple_expect_src_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  float_24_8     wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output float_24_8     rdata
);

  float_24_8 mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/simple_expect_src.sv
// Replays a RAM-held frame of expected values as a valid/ready/first stream.
// Define SIMPLE_EXPECT_SRC_REPEAT_EN to add the repeat_en input for looping frames.
module simple_expect_src
  import simple_expect_src_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_vld,
  input  logic [AW-1:0]       load_addr,
  input  float_24_8           load_data,
  input  logic                start,
  input  logic [AW:0]         frame_len,
`ifdef SIMPLE_EXPECT_SRC_REPEAT_EN
  input  logic                repeat_en,
`endif
  simple_expect_src_if.master exp_if,
  output logic                busy,
  output logic                done
);

  simple_expect_src_state_t state;
  logic [AW:0]   len, len_m1;
  logic [AW-1:0] rd_addr;
  logic          inflight, inflight_fst;
  float_24_8     rdata;
  float_24_8     fifo_data [SIMPLE_EXPECT_SRC_FIFO_DEPTH];
  logic [SIMPLE_EXPECT_SRC_FIFO_DEPTH-1:0] fifo_fst;
  logic          wr_ptr, rd_ptr;
  logic [1:0]    count, next_total;
  logic          vld, pop, fifo_pop, push, issue, rd_last, wrap;

  simple_expect_src_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (load_vld),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (rdata)
  );

`ifdef SIMPLE_EXPECT_SRC_REPEAT_EN
  assign wrap = repeat_en;
`else
  assign wrap = 1'b0;
`endif

  // The in-flight read result is the stream head when the FIFO is empty, so it
  // is either popped straight through or parked in the FIFO.
  assign vld        = (count != 2'd0) || inflight;
  assign pop        = vld && exp_if.expected_rdy;
  assign fifo_pop   = pop && (count != 2'd0);
  assign push       = inflight && !(count == 2'd0 && pop);
  assign next_total = count + 2'(inflight) - 2'(pop);
  assign issue      = (state == RUN) && (next_total < 2'(SIMPLE_EXPECT_SRC_FIFO_DEPTH));
  assign len_m1     = len - (AW+1)'(1);
  assign rd_last    = ({1'b0, rd_addr} == len_m1);

  assign exp_if.expected_vld = vld;
  assign exp_if.expected     = !vld ? '0 : (count != 2'd0) ? fifo_data[rd_ptr] : rdata;
  assign exp_if.expected_fst = !vld ? 1'b0 : (count != 2'd0) ? fifo_fst[rd_ptr] : inflight_fst;
  assign busy                = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      rd_addr      <= '0;
      inflight     <= 1'b0;
      inflight_fst <= 1'b0;
      fifo_fst     <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= '0;
      done         <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) inflight_fst <= (rd_addr == '0);
      if (push) begin
        fifo_fst[wr_ptr] <= inflight_fst;
        wr_ptr           <= ~wr_ptr;
      end
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(fifo_pop);

      case (state)
        IDLE: if (start && frame_len != '0) begin
          len     <= (frame_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : frame_len;
          rd_addr <= '0;
          state   <= RUN;
        end
        RUN: if (issue) begin
          if (rd_last) begin
            rd_addr <= '0;
            if (!wrap) state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + AW'(1);
          end
        end
        // Nothing left to issue; finish once the final beat leaves.
        DRAIN: if (pop && next_total == 2'd0) begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simple_expect_src.sv
// Directed bench for simple_expect_src: timing, stalls, clamping, restart, reset, repeat.
module tb_simple_expect_src;
  import simple_expect_src_pkg::*;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam logic [31:0] F1 = 32'h3F80_0000;
  localparam logic [31:0] F2 = 32'h4000_0000;
  localparam logic [31:0] F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000;
  localparam logic [31:0] F5 = 32'h40A0_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_vld;
  logic [AW-1:0] load_addr;
  float_24_8     load_data;
  logic          start;
  logic [AW:0]   frame_len;
  logic          repeat_en;
  logic          busy, done;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_d [DEPTH];
  logic        exp_f [DEPTH];

  simple_expect_src_if exp_if ();

  simple_expect_src #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_vld  (load_vld),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .frame_len (frame_len),
`ifdef SIMPLE_EXPECT_SRC_REPEAT_EN
    .repeat_en (repeat_en),
`endif
    .exp_if    (exp_if),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    load_vld  = 1'b1;
    load_addr = AW'(addr);
    load_data = data;
    step();
    load_vld  = 1'b0;
  endtask

  task automatic set_exp4(input logic [31:0] d0, d1, d2, d3);
    for (int i = 0; i < DEPTH; i++) exp_f[i] = 1'b0;
    exp_d[0] = d0; exp_d[1] = d1; exp_d[2] = d2; exp_d[3] = d3;
    exp_f[0] = 1'b1;
  endtask

  // Called in the cycle start is driven; collects n beats against exp_d/exp_f,
  // checks stall stability and that done pulses the cycle after the last accept.
  task automatic run_frame(input int n, input bit toggle, input int budget, input int drop_at);
    int          got, last_acc;
    bit          seen_done, stalled;
    logic [31:0] held_d;
    logic        held_f;
    got = 0; last_acc = -100; seen_done = 0; stalled = 0; held_d = '0; held_f = 1'b0;
    for (int cyc = 1; cyc <= budget && !seen_done; cyc++) begin
      step();
      start    = 1'b0;
      load_vld = 1'b0;
      exp_if.expected_rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      if (cyc == drop_at) repeat_en = 1'b0;
      if (stalled) begin
        check("stall_vld", exp_if.expected_vld, 1);
        check("stall_data", exp_if.expected, held_d);
        check("stall_fst", exp_if.expected_fst, held_f);
      end
      if (done) begin
        seen_done = 1;
        check("done_beats", got, n);
        check("done_gap", cyc - last_acc, 1);
        check("done_vld", exp_if.expected_vld, 0);
        check("done_busy", busy, 0);
      end else begin
        stalled = exp_if.expected_vld && !exp_if.expected_rdy;
        held_d  = exp_if.expected;
        held_f  = exp_if.expected_fst;
        if (exp_if.expected_vld && exp_if.expected_rdy) begin
          if (got < n) begin
            check($sformatf("beat%0d_data", got), exp_if.expected, exp_d[got]);
            check($sformatf("beat%0d_fst", got), exp_if.expected_fst, exp_f[got]);
          end else begin
            check("extra_beat", exp_if.expected_vld, 0);
          end
          got++;
          last_acc = cyc;
        end
      end
    end
    check("done_seen", seen_done, 1);
    step();
    check("done_pulse", done, 0);
  endtask

  initial begin
    reset = 1'b1; load_vld = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; frame_len = '0; repeat_en = 1'b0; exp_if.expected_rdy = 1'b1;
    #2;
    check("rst_vld", exp_if.expected_vld, 0);
    check("rst_fst", exp_if.expected_fst, 0);
    check("rst_data", exp_if.expected, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step(); step();
    reset = 1'b0;

    load(0, F1); load(1, F2); load(2, F3); load(3, F4);

    // Full-rate frame with exact cycle timing
    set_exp4(F1, F2, F3, F4);
    frame_len = 4; start = 1'b1;
    step(); start = 1'b0;
    check("t1_c1_busy", busy, 1);
    check("t1_c1_vld", exp_if.expected_vld, 0);
    for (int c = 2; c <= 5; c++) begin
      step();
      check($sformatf("t1_c%0d_vld", c), exp_if.expected_vld, 1);
      check($sformatf("t1_c%0d_data", c), exp_if.expected, exp_d[c-2]);
      check($sformatf("t1_c%0d_fst", c), exp_if.expected_fst, exp_f[c-2]);
    end
    step();
    check("t1_c6_done", done, 1);
    check("t1_c6_vld", exp_if.expected_vld, 0);
    check("t1_c6_busy", busy, 0);
    step();
    check("t1_c7_done", done, 0);

    // Toggling ready
    frame_len = 4; start = 1'b1;
    run_frame(4, 1'b1, 40, -1);

    // Second start mid-frame is ignored; late write to address 3 is seen
    set_exp4(F1, F2, F3, F5);
    exp_if.expected_rdy = 1'b0;
    frame_len = 4; start = 1'b1;
    step(); start = 1'b0;
    step();
    start = 1'b1; frame_len = 2;
    load_vld = 1'b1; load_addr = 3; load_data = F5;
    check("t4_busy", busy, 1);
    check("t4_head_fst", exp_if.expected_fst, 1);
    check("t4_head_data", exp_if.expected, F1);
    run_frame(4, 1'b0, 30, -1);

    // Reset after two accepted beats, then replay from address 0
    load(3, F4);
    set_exp4(F1, F2, F3, F4);
    exp_if.expected_rdy = 1'b1;
    frame_len = 4; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    check("t5_pre_vld", exp_if.expected_vld, 1);
    reset = 1'b1;
    #1;
    check("t5_rst_vld", exp_if.expected_vld, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_data", exp_if.expected, 0);
    step();
    reset = 1'b0;
    frame_len = 4; start = 1'b1;
    run_frame(4, 1'b0, 20, -1);

`ifdef SIMPLE_EXPECT_SRC_REPEAT_EN
    // Two passes of a 3-entry frame; repeat dropped during the second pass
    for (int i = 0; i < DEPTH; i++) exp_f[i] = 1'b0;
    exp_d[0] = F1; exp_d[1] = F2; exp_d[2] = F3;
    exp_d[3] = F1; exp_d[4] = F2; exp_d[5] = F3;
    exp_f[0] = 1'b1; exp_f[3] = 1'b1;
    repeat_en = 1'b1; frame_len = 3; start = 1'b1;
    run_frame(6, 1'b0, 30, 4);
`endif

    // Zero-length start is ignored
    frame_len = 0; start = 1'b1;
    step(); start = 1'b0;
    check("len0_busy", busy, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("len0_done", done, 0);
      check("len0_vld", exp_if.expected_vld, 0);
    end

    // Oversized frame clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) begin
      exp_d[i] = 32'h4100_0000 + 32'(i);
      exp_f[i] = (i == 0);
      load(i, exp_d[i]);
    end
    frame_len = 100; start = 1'b1;
    run_frame(DEPTH, 1'b0, 200, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
